// File: rtl/fpu_pipe_sequencer_if.sv
// Bundle of the core request/response handshakes and the fixed-latency unit link.
// The sequencer takes the slave side; the core+unit environment takes the master side.
interface fpu_pipe_sequencer_if #(
    parameter int TAG_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x1;
    logic [31:0]      req_x2;
    logic [TAG_W-1:0] req_tag;
    logic             unit_valid;
    logic [31:0]      unit_x1;
    logic [31:0]      unit_x2;
    logic             unit_out_valid;
    logic [31:0]      unit_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             err;

    modport master (
        output req_valid, req_x1, req_x2, req_tag, unit_out_valid, unit_y, rsp_ready,
        input  req_ready, unit_valid, unit_x1, unit_x2, rsp_valid, rsp_y, rsp_tag, busy, err
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag, unit_out_valid, unit_y, rsp_ready,
        output req_ready, unit_valid, unit_x1, unit_x2, rsp_valid, rsp_y, rsp_tag, busy, err
    );
endinterface

// File: rtl/fpu_pipe_sequencer.sv
// Issue sequencer for a non-stallable fixed-latency FPU unit: carries tags beside the
// unit pipeline and buffers results in a credit-protected FIFO for core writeback.
module fpu_pipe_sequencer #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 6,
    parameter int DEPTH   = 4
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    fpu_pipe_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]      credit_reg, credit_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic               err_reg;

    logic [LATENCY-1:0] tp_v_reg, tp_v_next;
    logic [TAG_W-1:0]   tp_tag_reg  [LATENCY];
    logic [TAG_W-1:0]   tp_tag_next [LATENCY];

    logic [TAG_W+31:0]  mem [DEPTH];

    logic ready, issue, push, pop, fifo_full, fifo_nonempty, write_en, tail_v;
    logic [TAG_W-1:0] tail_tag;

    // Credit covers both in-flight and buffered ops, so a result always has a slot.
    assign ready         = (credit_reg < CW'(DEPTH));
    assign issue         = bus.req_valid & ready;
    assign fifo_full     = (count_reg == CW'(DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign push          = bus.unit_out_valid;
    assign pop           = fifo_nonempty & bus.rsp_ready;
    assign write_en      = push & (~fifo_full | pop);
    assign tail_v        = tp_v_reg[LATENCY-1];
    assign tail_tag      = tp_tag_reg[LATENCY-1];

    assign bus.req_ready  = ready;
    assign bus.unit_valid = issue;
    assign bus.unit_x1    = bus.req_x1;
    assign bus.unit_x2    = bus.req_x2;
    assign bus.rsp_valid  = fifo_nonempty;
    assign {bus.rsp_tag, bus.rsp_y} = mem[rd_ptr_reg];
    assign bus.busy       = (credit_reg != '0);
    assign bus.err        = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign tp_v_next[gi]   = issue;
                assign tp_tag_next[gi] = bus.req_tag;
            end else begin : g_body
                assign tp_v_next[gi]   = tp_v_reg[gi-1];
                assign tp_tag_next[gi] = tp_tag_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        credit_next = credit_reg;
        if (issue && !pop)
            credit_next = credit_reg + 1'b1;
        else if (pop && !issue)
            credit_next = credit_reg - 1'b1;
    end

    always_comb begin
        count_next = count_reg;
        if (write_en && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !write_en)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            tp_v_reg <= '0;
        end else begin
            tp_v_reg <= tp_v_next;
        end
        tp_tag_reg <= tp_tag_next;
    end

    // Result storage is never reset; only the pointers and count define its contents.
    always_ff @(posedge sys_clk) begin
        if (write_en)
            mem[wr_ptr_reg] <= {tail_tag, bus.unit_y};
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            credit_reg <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            credit_reg <= credit_next;
            count_reg  <= count_next;
            if (write_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if ((push != tail_v) || (push && fifo_full && !pop))
                err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_pipe_sequencer.sv
// Directed + random bench: a behavioural fsub unit of fixed latency, and a queue-based
// reference of outstanding ops that predicts ready/busy/response timing and order.
module tb_fpu_pipe_sequencer;
    localparam int LAT   = 3;
    localparam int TAG_W = 6;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fpu_pipe_sequencer_if #(.TAG_W(TAG_W)) bus ();

    fpu_pipe_sequencer #(.LATENCY(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .sys_clk (clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    function automatic real sp2real(logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Attached unit: fsub with LAT cycles of latency, cleared by the shared reset.
    logic [LAT-1:0] uv;
    logic [31:0]    uy [LAT];
    logic           inject = 1'b0;
    always @(posedge clk) begin
        if (!rstn) uv <= '0;
        else       uv <= {uv[LAT-2:0], bus.unit_valid};
        uy[0] <= real2sp(sp2real(bus.unit_x1) - sp2real(bus.unit_x2));
        for (int i = 1; i < LAT; i++) uy[i] <= uy[i-1];
    end
    assign bus.unit_out_valid = uv[LAT-1] | inject;
    assign bus.unit_y         = uy[LAT-1];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
        int               arrive;
    } op_t;

    op_t              q[$];
    logic [TAG_W-1:0] got_tags[$];
    int  cyc = 0, n_checks = 0, n_fail = 0, n_issued = 0;
    int  a_cur = 0, b_cur = 0;
    logic exp_err = 1'b0;
    bit  check_en = 0, sb_en = 1;

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic set_op(bit v, int a, int b, int tag);
        a_cur = a;
        b_cur = b;
        bus.req_valid = v;
        bus.req_x1    = real2sp(real'(a));
        bus.req_x2    = real2sp(real'(b));
        bus.req_tag   = TAG_W'(tag);
    endtask

    // One clock cycle: compare against the reference at negedge, then advance it.
    task automatic tick();
        bit er, ev;
        op_t op;
        @(negedge clk);
        er = (q.size() < DEPTH);
        ev = (q.size() > 0) && (q[0].arrive <= cyc);
        if (check_en) begin
            chk("req_ready", 64'(bus.req_ready), 64'(er));
            chk("unit_valid", 64'(bus.unit_valid), 64'(bus.req_valid & er));
            chk("err", 64'(bus.err), 64'(exp_err));
            if (sb_en) begin
                chk("busy", 64'(bus.busy), 64'(q.size() != 0));
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
                if (ev) begin
                    chk("rsp_y", 64'(bus.rsp_y), 64'(q[0].y));
                    chk("rsp_tag", 64'(bus.rsp_tag), 64'(q[0].tag));
                end
            end
        end
        if (!rstn) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            if (inject) exp_err = 1'b1;
            if (ev && bus.rsp_ready) begin
                got_tags.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (bus.req_valid && er) begin
                op.tag    = bus.req_tag;
                op.y      = real2sp(real'(a_cur - b_cur));
                op.arrive = cyc + LAT + 1;
                q.push_back(op);
                n_issued++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        for (int k = 0; k < budget && (q.size() != 0 || bus.rsp_valid); k++) tick();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, n0, i, t;
        set_op(0, 0, 0, 0);
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        check_en = 1;
        chk("reset_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_err", 64'(bus.err), 64'd0);
        tick();

        // Single op: 3.0 - 1.0, tag 5
        bus.rsp_ready = 1'b1;
        set_op(1, 3, 1, 5);
        c0 = cyc;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.rsp_valid; k++) tick();
        chk("t1_latency", 64'(cyc - c0), 64'(LAT + 1));
        chk("t1_rsp_y", 64'(bus.rsp_y), 64'h4000_0000);
        chk("t1_rsp_tag", 64'(bus.rsp_tag), 64'd5);
        tick();
        drain(10);

        // Back-pressure: six offers with rsp_ready low
        got_tags.delete();
        bus.rsp_ready = 1'b0;
        n0 = n_issued;
        for (t = 0; t < 6; t++) begin
            set_op(1, $urandom_range(1000), $urandom_range(1000), t);
            if (t == 4) chk("t2_ready_low", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        chk("t2_accepted", 64'(n_issued - n0), 64'd4);
        repeat (5) tick();
        chk("t2_err", 64'(bus.err), 64'd0);

        // Drain in order
        bus.rsp_ready = 1'b1;
        drain(20);
        chk("t3_count", 64'(got_tags.size()), 64'd4);
        for (int k = 0; k < got_tags.size(); k++) chk("t3_order", 64'(got_tags[k]), 64'(k));
        chk("t3_busy", 64'(bus.busy), 64'd0);

        // Stream of 20 ops; with DEPTH = LATENCY+1 issue pauses briefly for credit
        got_tags.delete();
        i = 0;
        set_op(1, $urandom_range(1000), $urandom_range(1000), 10);
        for (int k = 0; k < 200 && i < 20; k++) begin
            n0 = n_issued;
            tick();
            if (n_issued != n0) begin
                i++;
                set_op(i < 20, $urandom_range(1000), $urandom_range(1000), 10 + i);
            end
        end
        bus.req_valid = 1'b0;
        drain(30);
        chk("t4_count", 64'(got_tags.size()), 64'd20);
        for (int k = 0; k < got_tags.size(); k++) chk("t4_order", 64'(got_tags[k]), 64'(10 + k));

        // Random valid/ready traffic
        for (int k = 0; k < 300; k++) begin
            set_op($urandom_range(1), $urandom_range(1000), $urandom_range(1000), $urandom_range(63));
            bus.rsp_ready = ($urandom_range(9) < 7);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain(40);

        // Protocol fault: unit result with nothing in flight
        bus.rsp_ready = 1'b0;
        sb_en = 0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (3) tick();
        chk("t5_err_held", 64'(bus.err), 64'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        sb_en = 1;
        chk("t5_err_cleared", 64'(bus.err), 64'd0);
        tick();

        // Reset with two ops in flight
        bus.rsp_ready = 1'b1;
        set_op(1, 7, 2, 1);
        tick();
        set_op(1, 9, 4, 2);
        tick();
        bus.req_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_ready", 64'(bus.req_ready), 64'd1);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
